// File: rtl/myproject_mac_pkg.sv
// Shared widths, limits and beat classification for the pipelined MAC.
// Width helpers keep the product and accumulator sizing in one place.
package myproject_mac_pkg;

  localparam int NUM_STAGE_MAX = 4;

  typedef enum logic [1:0] {
    BEAT_SINGLE,
    BEAT_ACC,
    BEAT_LAST
  } beat_t;

  function automatic int prod_w(input int din0_w, input int din1_w);
    return din0_w + din1_w + 1;
  endfunction

  function automatic int acc_w(input int din0_w, input int din1_w, input int guard);
    return prod_w(din0_w, din1_w) + guard;
  endfunction

endpackage

// File: rtl/myproject_mac_sat.sv
// Combinational accumulator-to-result converter producing dout and ovf.
// MYPROJECT_MAC_SAT_EN selects clamping; otherwise the result wraps.
module myproject_mac_sat
  import myproject_mac_pkg::*;
#(
  parameter int ACC_W      = 21,
  parameter int DOUT_WIDTH = 16
) (
  input  logic signed [ACC_W-1:0]      res,
  output logic        [DOUT_WIDTH-1:0] dout,
  output logic                         ovf
);

  generate
    if (ACC_W > DOUT_WIDTH) begin : g_narrow
      // In range exactly when every bit from the result MSB down to the sign bit agrees.
      logic [ACC_W-DOUT_WIDTH:0] top_bits;
      assign top_bits = res[ACC_W-1:DOUT_WIDTH-1];
      assign ovf      = !((&top_bits) || !(|top_bits));

`ifdef MYPROJECT_MAC_SAT_EN
      always_comb begin
        // NOTE: default first so every path assigns dout and no latch is inferred.
        dout = res[DOUT_WIDTH-1:0];
        if (ovf) begin
          dout = res[ACC_W-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                              : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
        end
      end
`else
      assign dout = res[DOUT_WIDTH-1:0];
`endif
    end else begin : g_wide
      assign dout = DOUT_WIDTH'(res);
      assign ovf  = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/myproject_mac_pipe_9s_7ns_16.sv
// Pipelined signed x (un)signed multiply-accumulate with valid/ready flow control.
// Output saturation is enabled by defining MYPROJECT_MAC_SAT_EN (handled in myproject_mac_sat).
module myproject_mac_pipe_9s_7ns_16
  import myproject_mac_pkg::*;
#(
  parameter int DIN0_WIDTH  = 9,
  parameter int DIN1_WIDTH  = 7,
  parameter int DIN1_SIGNED = 0,
  parameter int DOUT_WIDTH  = 16,
  parameter int NUM_STAGE   = 2,  // 1..NUM_STAGE_MAX
  parameter int ACC_GUARD   = 4
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  acc_en,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int PROD_W = prod_w(DIN0_WIDTH, DIN1_WIDTH);
  localparam int ACC_W  = acc_w(DIN0_WIDTH, DIN1_WIDTH, ACC_GUARD);
  localparam int NPRE   = NUM_STAGE - 1;

  typedef struct packed {
    logic                     vld;
    beat_t                    beat;
    logic signed [PROD_W-1:0] p;
  } stage_t;

  // One global advance: a stalled output freezes every stage, so bubbles are kept.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic        [DIN1_WIDTH:0] din1_x;
  logic signed [PROD_W-1:0]   op0, op1, prod;

  assign din1_x = {(DIN1_SIGNED != 0) ? din1[DIN1_WIDTH-1] : 1'b0, din1};
  assign op0    = {{(PROD_W-DIN0_WIDTH){din0[DIN0_WIDTH-1]}}, din0};
  assign op1    = {{(PROD_W-DIN1_WIDTH-1){din1_x[DIN1_WIDTH]}}, din1_x};
  assign prod   = op0 * op1;

  stage_t s_in, fin;

  always_comb begin
    s_in.vld  = in_valid;
    s_in.p    = prod;
    s_in.beat = acc_en ? (in_last ? BEAT_LAST : BEAT_ACC) : BEAT_SINGLE;
  end

  generate
    if (NPRE > 0) begin : g_pipe
      stage_t pipe_q [1:NPRE];

      // NOTE: payload is reset along with the valid bit; the registers are few and it keeps X out of the datapath.
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          for (int i = 1; i <= NPRE; i++) pipe_q[i] <= '0;
        end else if (adv) begin
          pipe_q[1] <= s_in;
          for (int i = 2; i <= NPRE; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign fin = pipe_q[NPRE];
    end else begin : g_comb
      assign fin = s_in;
    end
  endgenerate

  logic signed [ACC_W-1:0]      acc_q, p_ext, sum, res;
  logic        [DOUT_WIDTH-1:0] dout_c;
  logic                         ovf_c;

  assign p_ext = ACC_W'($signed(fin.p));
  assign sum   = acc_q + p_ext;
  assign res   = (fin.beat == BEAT_LAST) ? sum : p_ext;

  myproject_mac_sat #(
    .ACC_W      (ACC_W),
    .DOUT_WIDTH (DOUT_WIDTH)
  ) u_sat (
    .res  (res),
    .dout (dout_c),
    .ovf  (ovf_c)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q     <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
      ovf       <= 1'b0;
    end else if (adv) begin
      out_valid <= fin.vld && (fin.beat != BEAT_ACC);
      if (fin.vld) begin
        acc_q <= (fin.beat == BEAT_ACC) ? sum : '0;
        if (fin.beat != BEAT_ACC) begin
          dout <= dout_c;
          ovf  <= ovf_c;
        end
      end
    end
  end

endmodule
